// File: rtl/time_counter_pkg.sv
// Shared types, limits and BCD arithmetic helpers for the MM:SS time counter.
package time_pkg;

    typedef logic [7:0] bcd2_t;

    typedef struct packed {
        logic  carry;
        bcd2_t value;
    } bcd_res_t;

    localparam bcd2_t SEC_MAX = 8'h59;
    localparam bcd2_t MIN_MAX = 8'h59;

    // Two-digit BCD increment; carry is set when v was at max and wraps to 00.
    function automatic bcd_res_t bcd_inc(input bcd2_t v, input bcd2_t max);
        bcd_res_t r;
        if (v == max) begin
            r.carry = 1'b1;
            r.value = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r.carry = 1'b0;
            r.value = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r.carry = 1'b0;
            r.value = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Two-digit BCD decrement; carry (borrow) is set when v was 00 and wraps to max.
    function automatic bcd_res_t bcd_dec(input bcd2_t v, input bcd2_t max);
        bcd_res_t r;
        if (v == 8'h00) begin
            r.carry = 1'b1;
            r.value = max;
        end else if (v[3:0] == 4'd0) begin
            r.carry = 1'b0;
            r.value = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r.carry = 1'b0;
            r.value = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/time_counter_if.sv
// Control/status bundle between the mode FSM (master) and the time counter (slave).
interface time_counter_if;
    import time_pkg::*;

    logic  clear;
    logic  enable;
    logic  enable_increment;
    logic  enable_decrement;
    logic  inc_pulse;
    bcd2_t min_bcd;
    bcd2_t sec_bcd;
    logic  flag;
    logic  tick;

    modport master (
        output clear, enable, enable_increment, enable_decrement, inc_pulse,
        input  min_bcd, sec_bcd, flag, tick
    );

    modport slave (
        input  clear, enable, enable_increment, enable_decrement, inc_pulse,
        output min_bcd, sec_bcd, flag, tick
    );
endinterface

// File: rtl/time_counter_prescaler.sv
// Divides clk down to one sec_event per TICKS_PER_SEC running cycles; holds while paused.
module tick_prescaler #(
    parameter int TICKS_PER_SEC = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic sec_event
);
    localparam int W = $clog2(TICKS_PER_SEC);
    localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

    logic [W-1:0] count_r;

    // Prescale counter: wraps at LAST, keeps the partial second when run drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (run) begin
            if (count_r == LAST) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign sec_event = run & (count_r == LAST);
endmodule

// File: rtl/time_counter.sv
// MM:SS BCD timekeeping datapath: stopwatch up count, minute entry, countdown with sticky flag.
// Optional feature macro: TIME_COUNTER_SATURATE_EN (saturate at 59:59 / 59 instead of wrapping).
module time_counter
    import time_pkg::*;
#(
    parameter int TICKS_PER_SEC = 10_000_000
) (
    input  logic           clk,
    input  logic           rst,
    time_counter_if.slave  bus
);
    bcd2_t    min_r, sec_r, min_n, sec_n;
    logic     flag_r, flag_n, tick_r, tick_n;
    logic     run_s, sec_event_s, count_zero_s, last_second_s;
    bcd_res_t sec_inc_s, min_inc_s, sec_dec_s, min_dec_s;

    // Frozen once flagged, so a finished countdown cannot drift.
    assign run_s = (bus.enable | bus.enable_decrement) & ~flag_r;

    tick_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.clear),
        .run       (run_s),
        .sec_event (sec_event_s)
    );

    assign sec_inc_s = bcd_inc(sec_r, SEC_MAX);
    assign min_inc_s = bcd_inc(min_r, MIN_MAX);
    assign sec_dec_s = bcd_dec(sec_r, SEC_MAX);
    assign min_dec_s = bcd_dec(min_r, MIN_MAX);

    // Borrow-out of both digits pairs means the count is 00:00.
    assign count_zero_s  = sec_dec_s.carry & min_dec_s.carry;
    assign last_second_s = min_dec_s.carry & (sec_r == 8'h01);

    // Next-state selection in priority order clear > decrement > up count > minute entry.
    always_comb begin
        min_n  = min_r;
        sec_n  = sec_r;
        flag_n = flag_r;
        tick_n = 1'b0;
        if (bus.clear) begin
            min_n  = 8'h00;
            sec_n  = 8'h00;
            flag_n = 1'b0;
        end else if (bus.enable_decrement) begin
            if (count_zero_s) begin
                flag_n = 1'b1;
            end else if (sec_event_s) begin
                tick_n = 1'b1;
                sec_n  = sec_dec_s.value;
                if (sec_dec_s.carry) begin
                    min_n = min_dec_s.value;
                end else begin
                    min_n = min_r;
                end
                flag_n = last_second_s;
            end else begin
                tick_n = 1'b0;
            end
        end else if (bus.enable) begin
            if (sec_event_s) begin
                tick_n = 1'b1;
                if (sec_inc_s.carry && min_inc_s.carry) begin
`ifdef TIME_COUNTER_SATURATE_EN
                    min_n = MIN_MAX;
                    sec_n = SEC_MAX;
`else
                    min_n = 8'h00;
                    sec_n = 8'h00;
`endif
                end else if (sec_inc_s.carry) begin
                    sec_n = sec_inc_s.value;
                    min_n = min_inc_s.value;
                end else begin
                    sec_n = sec_inc_s.value;
                end
            end else begin
                tick_n = 1'b0;
            end
        end else if (bus.enable_increment) begin
            if (bus.inc_pulse) begin
`ifdef TIME_COUNTER_SATURATE_EN
                if (min_inc_s.carry) begin
                    min_n = MIN_MAX;
                end else begin
                    min_n = min_inc_s.value;
                end
`else
                min_n = min_inc_s.value;
`endif
            end else begin
                min_n = min_r;
            end
        end else begin
            tick_n = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_r  <= 8'h00;
            sec_r  <= 8'h00;
            flag_r <= 1'b0;
            tick_r <= 1'b0;
        end else begin
            min_r  <= min_n;
            sec_r  <= sec_n;
            flag_r <= flag_n;
            tick_r <= tick_n;
        end
    end

    assign bus.min_bcd = min_r;
    assign bus.sec_bcd = sec_r;
    assign bus.flag    = flag_r;
    assign bus.tick    = tick_r;
endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter: integer-seconds reference model, directed plus random stimulus.
module tb_time_counter;
    localparam int TPS = 4;
`ifdef TIME_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [7:0] min;
        logic [7:0] sec;
        logic       flag;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    time_counter_if bus();

    time_counter #(.TICKS_PER_SEC(TPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   m_t = 0;      // model count in total seconds
    int   m_p = 0;      // model prescaler phase
    bit   m_f = 1'b0;
    bit   m_tick = 1'b0;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic model_step(input bit r, c, e, ei, ed, ip);
        bit run;
        bit ev;
        int m;
        if (r || c) begin
            m_t = 0; m_p = 0; m_f = 1'b0; m_tick = 1'b0;
            return;
        end
        run    = (e || ed) && !m_f;
        ev     = run && (m_p == TPS - 1);
        if (run) m_p = (m_p + 1) % TPS;
        m_tick = 1'b0;
        if (ed) begin
            if (m_t == 0) begin
                m_f = 1'b1;
            end else if (ev) begin
                m_t    = m_t - 1;
                m_tick = 1'b1;
                if (m_t == 0) m_f = 1'b1;
            end
        end else if (e) begin
            if (ev) begin
                m_tick = 1'b1;
                if (m_t == 59 * 60 + 59) m_t = SAT ? m_t : 0;
                else m_t = m_t + 1;
            end
        end else if (ei && ip) begin
            m = m_t / 60;
            if (m == 59) m = SAT ? 59 : 0;
            else m = m + 1;
            m_t = m * 60 + (m_t % 60);
        end
    endtask

    // Drive one clock cycle of inputs; the expected post-edge outputs go into the scoreboard.
    task automatic cyc(input bit r, c, e, ei, ed, ip);
        exp_t x;
        rst                  = r;
        bus.clear            = c;
        bus.enable           = e;
        bus.enable_increment = ei;
        bus.enable_decrement = ed;
        bus.inc_pulse        = ip;
        @(posedge clk);
        model_step(r, c, e, ei, ed, ip);
        x.min  = to_bcd(m_t / 60);
        x.sec  = to_bcd(m_t % 60);
        x.flag = m_f;
        x.tick = m_tick;
        exp_q.push_back(x);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every presented output cycle is popped and compared against the scoreboard.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                checks++;
                if ({bus.min_bcd, bus.sec_bcd, bus.flag, bus.tick} !== {x.min, x.sec, x.flag, x.tick}) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL scoreboard @%0t: got %h:%h flag=%b tick=%b, expected %h:%h flag=%b tick=%b",
                                 $time, bus.min_bcd, bus.sec_bcd, bus.flag, bus.tick,
                                 x.min, x.sec, x.flag, x.tick);
                end
            end
        end
    end

    initial begin
        int ticks;
        int mode;
        bit r, c, ip;

        // Reset
        repeat (2) cyc(1, 0, 0, 0, 0, 0);
        check("reset_min", bus.min_bcd, 8'h00);
        check("reset_sec", bus.sec_bcd, 8'h00);
        check("reset_flag", bus.flag, 0);
        check("reset_tick", bus.tick, 0);

        // 244 cycles of up count at 4 cycles/second -> 01:01
        ticks = 0;
        repeat (244) begin
            cyc(0, 0, 1, 0, 0, 0);
            if (bus.tick === 1'b1) ticks++;
        end
        check("up_min", bus.min_bcd, 8'h01);
        check("up_sec", bus.sec_bcd, 8'h01);
        check("up_tick_count", ticks, 61);

        // Reach 59:59 via minute entry and up count, then one more second
        cyc(0, 1, 0, 0, 0, 0);
        repeat (59) cyc(0, 0, 0, 1, 0, 1);
        check("entry_59_min", bus.min_bcd, 8'h59);
        check("entry_59_sec", bus.sec_bcd, 8'h00);
        repeat (59 * TPS) cyc(0, 0, 1, 0, 0, 0);
        check("preload_min", bus.min_bcd, 8'h59);
        check("preload_sec", bus.sec_bcd, 8'h59);
        repeat (TPS) cyc(0, 0, 1, 0, 0, 0);
        check("wrap_min", bus.min_bcd, SAT ? 8'h59 : 8'h00);
        check("wrap_sec", bus.sec_bcd, SAT ? 8'h59 : 8'h00);
        check("wrap_tick", bus.tick, 1);
        cyc(0, 0, 0, 1, 0, 1);
        check("entry_wrap_min", bus.min_bcd, SAT ? 8'h59 : 8'h01);

        // Input then countdown
        cyc(0, 1, 0, 0, 0, 0);
        repeat (3) begin
            cyc(0, 0, 0, 1, 0, 1);
            repeat ($urandom_range(0, 3)) cyc(0, 0, 0, 1, 0, 0);
        end
        check("entry3_min", bus.min_bcd, 8'h03);
        check("entry3_sec", bus.sec_bcd, 8'h00);
        repeat (TPS) cyc(0, 0, 0, 0, 1, 0);
        check("borrow_min", bus.min_bcd, 8'h02);
        check("borrow_sec", bus.sec_bcd, 8'h59);
        check("borrow_tick", bus.tick, 1);
        repeat (179 * TPS) cyc(0, 0, 0, 0, 1, 0);
        check("down_zero_min", bus.min_bcd, 8'h00);
        check("down_zero_sec", bus.sec_bcd, 8'h00);
        check("down_flag", bus.flag, 1);
        repeat (20) cyc(0, 0, 0, 0, 1, 0);
        check("frozen_flag", bus.flag, 1);
        check("frozen_sec", bus.sec_bcd, 8'h00);
        repeat (3 * TPS) cyc(0, 0, 1, 0, 0, 0);
        check("sticky_flag", bus.flag, 1);
        check("sticky_sec", bus.sec_bcd, 8'h00);

        // Immediate flag at 00:00
        cyc(0, 1, 0, 0, 0, 0);
        check("clear_flag", bus.flag, 0);
        cyc(0, 0, 0, 0, 1, 0);
        check("imm_flag", bus.flag, 1);
        check("imm_tick", bus.tick, 0);
        repeat (10) cyc(0, 0, 0, 0, 1, 0);

        // Clear beats a coincident prescaler wrap
        cyc(0, 1, 0, 0, 0, 0);
        repeat (TPS - 1) cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        check("clr_pri_sec", bus.sec_bcd, 8'h00);
        check("clr_pri_tick", bus.tick, 0);
        repeat (TPS - 1) cyc(0, 0, 1, 0, 0, 0);
        check("clr_pre_tick", bus.tick, 0);
        cyc(0, 0, 1, 0, 0, 0);
        check("clr_pre_sec", bus.sec_bcd, 8'h01);

        // Pause keeps the partial second
        cyc(0, 1, 0, 0, 0, 0);
        repeat (TPS - 1) cyc(0, 0, 1, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        check("pause_sec", bus.sec_bcd, 8'h01);
        check("pause_tick", bus.tick, 1);

        // Random segments of held modes
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 24 == 0) mode = $urandom_range(0, 4);
            r  = ($urandom_range(0, 499) == 0);
            c  = ($urandom_range(0, 199) == 0);
            ip = ($urandom_range(0, 2) == 0);
            case (mode)
                0:       cyc(r, c, 1, 0, 0, ip);
                1:       cyc(r, c, 0, 1, 0, ip);
                2:       cyc(r, c, 0, 0, 1, ip);
                3:       cyc(r, c, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), ip);
                default: cyc(r, c, 0, 0, 0, ip);
            endcase
        end
        cyc(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/time_counter.md
# time_counter

Timekeeping datapath driven by the mode control FSM. It holds an MM:SS count in BCD and generates a 1 Hz tick from the system clock. It counts up in stopwatch mode, accepts minute increments in timer-input mode, and counts down in timer mode. It raises the `flag` that moves the FSM into its time-up state. Outputs feed the display mux selected by the FSM's `output_select`.

## Interface
- `TICKS_PER_SEC`, default 10_000_000: clk cycles per second. Legal range is 2 or more.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clear` in 1: zero the count, prescaler and flag (FSM `clear`).
- `enable` in 1: count up at 1 Hz (FSM `enable`).
- `enable_increment` in 1: timer-input mode; `inc_pulse` adds one minute.
- `enable_decrement` in 1: count down at 1 Hz (FSM `enable_decrement`).
- `inc_pulse` in 1: single-cycle conditioned button pulse.
- `min_bcd` out 8: minutes, two BCD digits, range 00–59.
- `sec_bcd` out 8: seconds, two BCD digits, range 00–59.
- `flag` out 1: sticky time-up indication.
- `tick` out 1: one-cycle strobe for each counted second.

## Operation
- Reset: `min_bcd`=0x00, `sec_bcd`=0x00, `flag`=0, `tick`=0, prescaler=0.
- Priority per cycle: `rst` > `clear` > `enable_decrement` > `enable` > `enable_increment`. Only the highest-priority active mode acts.
- `clear`: same effect as reset. It overrides a coincident tick or pulse.
- Prescaler, width $clog2(TICKS_PER_SEC):
  - Advances only while `enable` or `enable_decrement` is high and `flag`=0.
  - Holds its value otherwise, so a pause keeps the partial second.
  - At TICKS_PER_SEC-1 it wraps to 0 and generates a second event.
- Up count (`enable`):
  - Each second event adds 1 to the seconds.
  - 59 wraps to 00 and carries into the minutes.
  - At 59:59 the count wraps to 00:00, unless changed by Configuration.
- Input mode (`enable_increment`):
  - Each `inc_pulse` adds 1 to the minutes; 59 wraps to 00. Seconds are untouched.
  - `inc_pulse` is ignored in every other mode.
- Down count (`enable_decrement`):
  - Each second event subtracts 1. Seconds 00 borrow from minutes and become 59.
  - When the count reaches 00:00 (the 00:01 → 00:00 transition), `flag` is set on that same edge.
  - If `enable_decrement` is high while the count is already 00:00, `flag` sets on the next edge.
  - With `flag`=1, the count and prescaler freeze.
- `flag` stays set until `clear` or `rst`. Dropping `enable_decrement` does not clear it.
- BCD digits always remain legal: units 0–9, tens 0–5.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- A second event updates `min_bcd`/`sec_bcd` on the edge where the prescaler equals TICKS_PER_SEC-1.
- `tick` is high for exactly the one cycle following that edge, coincident with the new count.
- An `inc_pulse` in cycle N is visible on `min_bcd` in cycle N+1.
- `clear` in cycle N gives zeroed outputs in cycle N+1.
- `flag` rises in the same cycle that the count first shows 00:00 during a down count.
- Back-to-back `inc_pulse` on consecutive cycles: each one is counted.

## Configuration
- `TIME_COUNTER_SATURATE_EN`
  - Defined: the up count saturates at 59:59 (tick still pulses, count holds), and input-mode minutes saturate at 59.
  - Undefined: both wrap to 00, as described above.

## Structure
- Package `time_pkg` holds:
  - `bcd2_t` (a logic [7:0] pair of BCD digits);
  - constants `SEC_MAX`=8'h59 and `MIN_MAX`=8'h59;
  - BCD increment and decrement functions with carry/borrow out.
- Sub-module `tick_prescaler` (parameter TICKS_PER_SEC; ports clk, rst, clear, run; output sec_event).
- `time_counter` holds the BCD registers and the flag logic.

## Test plan
- Reset: assert `rst` for 2 cycles → 00:00, `flag`=0, `tick`=0. Then `enable`=1 with TICKS_PER_SEC=4 for 244 cycles → 01:01, 61 `tick` pulses.
- Wrap: preload 59:59, `enable`=1, one second event → 00:00. With `TIME_COUNTER_SATURATE_EN` → 59:59 and `tick`=1.
- Input then countdown: `enable_increment` with 3 `inc_pulse` → 03:00. Switch to `enable_decrement`: one second event → 02:59. After 180 events → 00:00 and `flag`=1. Further cycles → count frozen, `flag` stays 1.
- Immediate flag: `enable_decrement`=1 at count 00:00 → `flag`=1 the next cycle, and `tick` never pulses.
- Clear priority: `clear`, `enable` and a prescaler wrap all in the same cycle → next cycle 00:00, prescaler 0, `tick`=0.
- Pause: `enable` for 3 of 4 prescale cycles, low for 10 cycles, then high again → second event arrives 1 cycle after re-enable, count 00:01.
